// File: rtl/countdown_timer.sv
// Programmable countdown timer with pause/resume, optional auto-reload,
// a one-cycle done pulse on each expiry and a wrapping expiry counter.
module countdown_timer #(
  parameter int WIDTH     = 32,
  parameter int DECREMENT = 1,
  parameter int EXPW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [EXPW-1:0]  expirations
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEC = WIDTH'(DECREMENT);

  if (DECREMENT < 1) begin : g_bad_decrement
    $error("countdown_timer: DECREMENT must be at least 1");
  end

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // Timer FSM: load beats start beats pause; busy and done are kept as
  // registers alongside the state so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      reload_reg  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      expirations <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count      <= load_value;
        reload_reg <= load_value;
        state      <= IDLE;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A zero count has nothing to time, so start is ignored.
            if (start && (count != '0)) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            // start outranks pause, and start in RUN simply keeps counting.
            if (pause && !start) begin
              state <= HOLD;
            end else if (count > DEC) begin
              count <= count - DEC;
            end else begin
              done        <= 1'b1;
              expirations <= expirations + EXPW'(1);
              // A zero reload value would fire done every cycle; stop instead.
              if (reload_en && (reload_reg != '0)) begin
                count <= reload_reg;
              end else begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (start) begin
              state <= RUN;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed bench for countdown_timer. Two instances share the
// stimulus (DECREMENT=1 and DECREMENT=4) and are each tracked by an
// arithmetic reference model of the timer's behaviour.
module tb_countdown_timer;

  localparam int W  = 8;
  localparam int EW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic         reload_en;

  logic [W-1:0]  cnt  [2];
  logic          busy [2];
  logic          done [2];
  logic [EW-1:0] exps [2];

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .DECREMENT(1), .EXPW(EW)) u_dec1 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .reload_en(reload_en),
    .count(cnt[0]), .busy(busy[0]), .done(done[0]), .expirations(exps[0])
  );

  countdown_timer #(.WIDTH(W), .DECREMENT(4), .EXPW(EW)) u_dec4 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .reload_en(reload_en),
    .count(cnt[1]), .busy(busy[1]), .done(done[1]), .expirations(exps[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a timer that is either stopped, counting or held.
  int m_count  [2];
  int m_reload [2];
  bit m_counting [2];
  bit m_held   [2];
  bit m_done   [2];
  int m_exp    [2];
  int dec_of   [2];

  // Observed done pulses per instance.
  int dn [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_count[i]    = 0;
      m_reload[i]   = 0;
      m_counting[i] = 1'b0;
      m_held[i]     = 1'b0;
      m_done[i]     = 1'b0;
      m_exp[i]      = 0;
    end
  endtask

  // Advance instance i by one clock using the currently driven inputs.
  task automatic model_step(input int i);
    m_done[i] = 1'b0;
    if (load) begin
      m_count[i]    = int'(load_value);
      m_reload[i]   = int'(load_value);
      m_counting[i] = 1'b0;
      m_held[i]     = 1'b0;
    end else if (m_held[i]) begin
      if (start) begin
        m_held[i]     = 1'b0;
        m_counting[i] = 1'b1;
      end
    end else if (!m_counting[i]) begin
      if (start && m_count[i] > 0) m_counting[i] = 1'b1;
    end else if (pause && !start) begin
      m_counting[i] = 1'b0;
      m_held[i]     = 1'b1;
    end else if (m_count[i] > dec_of[i]) begin
      m_count[i] = m_count[i] - dec_of[i];
    end else begin
      m_done[i] = 1'b1;
      m_exp[i]  = (m_exp[i] + 1) % (1 << EW);
      if (reload_en && m_reload[i] > 0) begin
        m_count[i] = m_reload[i];
      end else begin
        m_count[i]    = 0;
        m_counting[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count[%0d]", i), 64'(cnt[i]), 64'(m_count[i]));
      chk($sformatf("busy[%0d]", i),  64'(busy[i]), 64'(m_counting[i] | m_held[i]));
      chk($sformatf("done[%0d]", i),  64'(done[i]), 64'(m_done[i]));
      chk($sformatf("expirations[%0d]", i), 64'(exps[i]), 64'(m_exp[i]));
      if (done[i] === 1'b1) dn[i]++;
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), update the
  // models, and compare at the following falling edge.
  task automatic step(input logic l, input logic [W-1:0] lv, input logic s,
                      input logic p, input logic r);
    load       = l;
    load_value = lv;
    start      = s;
    pause      = p;
    reload_en  = r;
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  int snap;

  initial begin
    dec_of[0] = 1;
    dec_of[1] = 4;
    dn[0] = 0;
    dn[1] = 0;
    rst = 1'b0;
    load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; reload_en = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Single countdown from 5 without reload: one done, then idle.
    snap = dn[0];
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    chk("r34_count_after_start", 64'(cnt[0]), 64'd5);
    repeat (6) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("r34_done_pulses", 64'(dn[0] - snap), 64'd1);

    // Auto-reload from 3: three expiries in nine cycles.
    snap = m_exp[0];
    step(1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    repeat (9) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("r35_expiries", 64'(exps[0]), 64'((snap + 3) % 16));
    step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

    // Pause at 7 for four cycles, then resume.
    step(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("r36_hold_count", 64'(cnt[0]), 64'd7);
    chk("r36_hold_busy", 64'(busy[0]), 64'd1);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("r36_resumed", 64'(cnt[0]), 64'd3);

    // DECREMENT=4 from 10: 10,6,2,0 with one done and no wrap.
    snap = dn[1];
    step(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("r37_final_count", 64'(cnt[1]), 64'd0);
    chk("r37_done_pulses", 64'(dn[1] - snap), 64'd1);

    // Load on the expiry cycle wins over the expiry.
    step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    snap = int'(exps[0]);
    step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    chk("r38_count", 64'(cnt[0]), 64'd9);
    chk("r38_done", 64'(done[0]), 64'd0);
    chk("r38_exp", 64'(exps[0]), 64'(snap));

    // Asynchronous reset mid-run at count 4, then start must be ignored.
    step(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("r39_before_reset", 64'(cnt[0]), 64'd4);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("r39_async_count", 64'(cnt[0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    chk("r39_start_ignored", 64'(busy[0]), 64'd0);

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      logic          l, s, p, r;
      logic [W-1:0]  lv;
      l  = ($urandom_range(0, 15) == 0);
      lv = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255))
                                       : W'($urandom_range(0, 20));
      s  = ($urandom_range(0, 4) == 0);
      p  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 1) == 1);
      step(l, lv, s, p, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
